// File: rtl/stopwatch_pkg.sv
// ============================================================================
//  Module : stopwatch_pkg
//  Brief  : Shared types and constants for the stopwatch time-keeping core.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package stopwatch_pkg;

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        ADJUST = 2'd2
    } state_t;

    localparam int DIGIT_W_DEF = 5;
    localparam int MAX_TEN_DEF = 5;

    localparam logic [3:0] BCD_ZERO      = 4'd0;
    localparam logic [3:0] BCD_UNITS_MAX = 4'd9;

endpackage

`default_nettype wire

// File: rtl/bcd_mod60.sv
// ============================================================================
//  Module : bcd_mod60
//  Brief  : Combinational two-digit BCD incrementer, wraps after MAX_TEN,9.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module bcd_mod60
    import stopwatch_pkg::*;
#(
    parameter int MAX_TEN = MAX_TEN_DEF
) (
    input  logic [3:0] tens_i,
    input  logic [3:0] units_i,
    input  logic       inc_i,
    output logic [3:0] tens_o,
    output logic [3:0] units_o,
    output logic       carry_o
);

    always_comb begin
        tens_o  = tens_i;
        units_o = units_i;
        carry_o = 1'b0;
        if (inc_i) begin
            if (units_i == BCD_UNITS_MAX) begin
                units_o = BCD_ZERO;
                if (tens_i == 4'(MAX_TEN)) begin
                    tens_o  = BCD_ZERO;
                    carry_o = 1'b1;
                end else begin
                    tens_o = tens_i + 4'd1;
                end
            end else begin
                units_o = units_i + 4'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/stopwatch_counter.sv
// ============================================================================
//  Module : stopwatch_counter
//  Brief  : MM:SS BCD stopwatch core with run/pause FSM, clear and field adjust.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int DIGIT_W = DIGIT_W_DEF,
    parameter int MAX_TEN = MAX_TEN_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_1hz,
    input  logic               tick_2hz,
    input  logic               pause,
    input  logic               clear,
    input  logic               adj,
    input  logic               sel,
    output logic [DIGIT_W-1:0] min_l,
    output logic [DIGIT_W-1:0] min_r,
    output logic [DIGIT_W-1:0] sec_l,
    output logic [DIGIT_W-1:0] sec_r,
    output logic               running,
    output logic               wrap
);

    state_t     state_q, state_d;
    logic       pause_q, clear_q;
    logic [3:0] min_l_q, min_r_q, sec_l_q, sec_r_q;
    logic [3:0] min_l_d, min_r_d, sec_l_d, sec_r_d;
    logic       wrap_q, wrap_d;

    logic       pause_re, clear_re;
    logic       sec_inc, min_inc, sec_carry, min_carry;
    logic       run_tick, adj_tick;
    logic [3:0] sec_l_nx, sec_r_nx, min_l_nx, min_r_nx;

    assign pause_re = pause & ~pause_q;
    assign clear_re = clear & ~clear_q;

    assign run_tick = (state_q == RUN)    & tick_1hz;
    assign adj_tick = (state_q == ADJUST) & tick_2hz;

    // In ADJUST each field wraps on its own; only RUN lets seconds carry into minutes.
    assign sec_inc = run_tick | (adj_tick & ~sel);
    assign min_inc = (run_tick & sec_carry) | (adj_tick & sel);

    bcd_mod60 #(.MAX_TEN(MAX_TEN)) u_sec (
        .tens_i  (sec_l_q),
        .units_i (sec_r_q),
        .inc_i   (sec_inc),
        .tens_o  (sec_l_nx),
        .units_o (sec_r_nx),
        .carry_o (sec_carry)
    );

    bcd_mod60 #(.MAX_TEN(MAX_TEN)) u_min (
        .tens_i  (min_l_q),
        .units_i (min_r_q),
        .inc_i   (min_inc),
        .tens_o  (min_l_nx),
        .units_o (min_r_nx),
        .carry_o (min_carry)
    );

    always_comb begin
        state_d = state_q;
        if (adj) begin
            state_d = ADJUST;
        end else if (state_q == ADJUST) begin
            state_d = PAUSED;
        end else if (pause_re) begin
            state_d = (state_q == RUN) ? PAUSED : RUN;
        end
    end

    always_comb begin
        sec_l_d = sec_l_nx;
        sec_r_d = sec_r_nx;
        min_l_d = min_l_nx;
        min_r_d = min_r_nx;
        wrap_d  = run_tick & sec_carry & min_carry;
        if (clear_re) begin
            sec_l_d = BCD_ZERO;
            sec_r_d = BCD_ZERO;
            min_l_d = BCD_ZERO;
            min_r_d = BCD_ZERO;
            wrap_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= PAUSED;
            pause_q <= 1'b0;
            clear_q <= 1'b0;
            sec_l_q <= BCD_ZERO;
            sec_r_q <= BCD_ZERO;
            min_l_q <= BCD_ZERO;
            min_r_q <= BCD_ZERO;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pause_q <= pause;
            clear_q <= clear;
            sec_l_q <= sec_l_d;
            sec_r_q <= sec_r_d;
            min_l_q <= min_l_d;
            min_r_q <= min_r_d;
            wrap_q  <= wrap_d;
        end
    end

    assign min_l   = DIGIT_W'(min_l_q);
    assign min_r   = DIGIT_W'(min_r_q);
    assign sec_l   = DIGIT_W'(sec_l_q);
    assign sec_r   = DIGIT_W'(sec_r_q);
    assign running = (state_q == RUN);
    assign wrap    = wrap_q;

endmodule

`default_nettype wire
